// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared definitions for the motion-estimation frame scheduler:
//   ME_CORE_CYCLES : edges from core start to core completed
//   state_t        : scheduler FSM states
//   result_t       : one per-macroblock result as presented on res_data
// ---------------------------------------------------------------------------
package me_pkg;

   localparam int ME_CORE_CYCLES = 4111;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      PUSH,
      CLEAR
   } state_t;

   // Packed MSB first: {mb_y, mb_x, motion_y, motion_x, best_dist}
   typedef struct packed {
      logic [3:0] mb_y;
      logic [3:0] mb_x;
      logic [3:0] motion_y;
      logic [3:0] motion_x;
      logic [7:0] best_dist;
   } result_t;

   localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/me_result_fifo.sv
// ---------------------------------------------------------------------------
// me_result_fifo
// Small synchronous FIFO for scheduler results. Storage is reset so that
// the head entry reads as zero straight after reset.
//   clock, reset : clock and asynchronous active-high reset
//   push_i       : write wdata_i (ignored while full, even if popping)
//   pop_i        : drop the head entry (ignored while empty)
//   wdata_i      : entry to write
//   rdata_o      : head entry
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
//   count_o      : current occupancy
// ---------------------------------------------------------------------------
module me_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 24
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // Full is judged on the pre-pop occupancy: no write-through when full.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               mem_q[gi] <= '0;
            end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
               mem_q[gi] <= wdata_i;
            end
         end
      end
   endgenerate

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/me_frame_scheduler.sv
// ---------------------------------------------------------------------------
// me_frame_scheduler
// Walks an MB_COLS x MB_ROWS macroblock grid in raster order. For each
// macroblock: ask the loader to fill the ROMs, run the ME core, capture its
// result and queue it in a result FIFO behind a valid/ready port.
//   clock, reset           : clock, asynchronous active-high reset
//   go_valid / go_ready    : frame request handshake (ready only in IDLE)
//   load_req / load_done   : loader handshake for macroblock (mb_x, mb_y)
//   mb_x, mb_y             : current macroblock index
//   me_start               : core start (low resets the core count)
//   me_completed, me_best_dist, me_motion_x, me_motion_y : core results
//   res_valid / res_ready / res_data : result stream
//   busy                   : not IDLE
//   frame_done             : one-cycle pulse after the last macroblock
// ---------------------------------------------------------------------------
module me_frame_scheduler
   import me_pkg::*;
#(
   parameter int MB_COLS    = 4,
   parameter int MB_ROWS    = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                go_valid,
   output logic                go_ready,
   output logic                load_req,
   input  logic                load_done,
   output logic [3:0]          mb_x,
   output logic [3:0]          mb_y,
   output logic                me_start,
   input  logic                me_completed,
   input  logic [7:0]          me_best_dist,
   input  logic [3:0]          me_motion_x,
   input  logic [3:0]          me_motion_y,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RESULT_W-1:0] res_data,
   output logic                busy,
   output logic                frame_done
);

   state_t     state_q, state_d;
   logic [3:0] mb_x_q, mb_x_d;
   logic [3:0] mb_y_q, mb_y_d;
   result_t    hold_q, hold_d;
   logic       frame_done_q, frame_done_d;

   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        unused_fifo_count;

   logic last_x;
   logic last_y;

   assign last_x = (mb_x_q == 4'(MB_COLS - 1));
   assign last_y = (mb_y_q == 4'(MB_ROWS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mb_x_q       <= '0;
         mb_y_q       <= '0;
         hold_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mb_x_q       <= mb_x_d;
         mb_y_q       <= mb_y_d;
         hold_q       <= hold_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mb_x_d       = mb_x_q;
      mb_y_d       = mb_y_q;
      hold_d       = hold_q;
      frame_done_d = 1'b0;
      fifo_push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (go_valid) begin
               mb_x_d  = '0;
               mb_y_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (load_done) state_d = RUN;
         end
         RUN: begin
            // Core outputs are sampled on this edge only; later changes on
            // the core bus are ignored.
            if (me_completed) begin
               hold_d.mb_y      = mb_y_q;
               hold_d.mb_x      = mb_x_q;
               hold_d.motion_y  = me_motion_y;
               hold_d.motion_x  = me_motion_x;
               hold_d.best_dist = me_best_dist;
               state_d          = PUSH;
            end
         end
         PUSH: begin
            // me_start stays high here so the core count is frozen while
            // waiting for FIFO space.
            if (!fifo_full) begin
               fifo_push = 1'b1;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            if (last_x) begin
               mb_x_d = '0;
               if (last_y) begin
                  mb_y_d       = '0;
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  mb_y_d  = mb_y_q + 4'd1;
                  state_d = LOAD;
               end
            end else begin
               mb_x_d  = mb_x_q + 4'd1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   me_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RESULT_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (hold_q),
      .rdata_o (res_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Occupancy is only of interest for debug at this level.
   assign unused_fifo_count = ^fifo_count;

   assign fifo_pop   = res_valid && res_ready;
   assign res_valid  = !fifo_empty;
   assign go_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign load_req   = (state_q == LOAD);
   assign me_start   = (state_q == RUN) || (state_q == PUSH);
   assign mb_x       = mb_x_q;
   assign mb_y       = mb_y_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/me_frame_scheduler.md
# me_frame_scheduler

Frame-level sequencer for the full-search motion-estimation core (`top`: control, PE array, comparator). It walks a grid of macroblocks in raster order and handshakes with an external loader that fills the R/S ROMs for each macroblock. For each macroblock it drives the core's `start`, captures the winning distortion and motion vector when `completed` rises, and queues the results in a small FIFO behind a valid/ready output port.

## Interface
Parameters:
- `MB_COLS`, default 4: macroblocks per row, 1..16.
- `MB_ROWS`, default 4: macroblock rows, 1..16.
- `FIFO_DEPTH`, default 2: result FIFO entries, power of 2, ≥2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared immediately.
- `go_valid` in 1: request to process one frame.
- `go_ready` out 1: high only in IDLE.
- `load_req` out 1: asks the loader to fill the ROMs for (`mb_x`,`mb_y`).
- `load_done` in 1: one-cycle ack from the loader.
- `mb_x`, `mb_y` out 4 each: current macroblock index.
- `me_start` out 1: drives core `start`.
- `me_completed` in 1: core `completed`.
- `me_best_dist` in 8: core `BestDist`.
- `me_motion_x`, `me_motion_y` in 4 each: core `motionX`/`motionY`.
- `res_valid` out 1: FIFO not empty.
- `res_ready` in 1: consumer accepts the head entry.
- `res_data` out 24: head entry `{mb_y, mb_x, motion_y, motion_x, best_dist}`, MSB first.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse after the last macroblock is captured.

## Operation
- States:
  - IDLE: `go_ready`=1. `go_valid`&`go_ready` sets `mb_x`=`mb_y`=0 and goes to LOAD.
  - LOAD: `load_req`=1, `me_start`=0. `load_done` goes to RUN.
  - RUN: `me_start`=1. The first cycle with `me_completed`=1 latches the core outputs and the current `mb_x`/`mb_y` into a hold register and goes to PUSH.
  - PUSH: `me_start` stays 1, which freezes the core count. If the FIFO has fewer than `FIFO_DEPTH` entries, write the hold register and go to CLEAR; otherwise stay in PUSH.
  - CLEAR: `me_start`=0 for exactly one cycle, which resets the core count. Advance the index: `mb_x`+1; at `MB_COLS`-1, `mb_x` wraps to 0 and `mb_y`+1. If the macroblock just finished was (`MB_COLS`-1, `MB_ROWS`-1), pulse `frame_done` and go to IDLE; otherwise go to LOAD.
- Core outputs are sampled only at the RUN→PUSH edge. Later changes on `me_best_dist` are ignored.
- `me_completed` outside RUN is ignored. `load_done` outside LOAD is ignored. `go_valid` outside IDLE is ignored and not queued.
- FIFO:
  - A pop occurs on `res_valid`&`res_ready`.
  - The push condition uses the pre-pop occupancy. There is no full-bypass: push while full is blocked even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - The FIFO keeps draining in IDLE. Results that remain after `frame_done` are valid.
- Reset values: state=IDLE, `go_ready`=1, `busy`=0, `load_req`=0, `me_start`=0, `mb_x`=`mb_y`=0, `res_valid`=0, `res_data`=0, `frame_done`=0, FIFO empty, hold register=0.
- Reset mid-frame: the FIFO contents are discarded. The core sees `me_start`=0 and clears its own count.

## Timing
- All outputs are registered, or decoded directly from registered state or the FIFO.
- Go accepted at edge n: `load_req`=1 in cycle n+1.
- `load_done` sampled at edge m: `load_req`=0 and `me_start`=1 from cycle m+1.
- Core runtime: `me_completed` rises 4111 edges after `me_start` rises.
- Capture: `me_completed` sampled at edge k puts the FIFO write at edge k+1 if the FIFO is not full; `res_valid` rises in cycle k+2.
- CLEAR lasts one cycle. The next `load_req` rises two cycles after the push edge.
- Per-macroblock overhead with no stalls: 4 cycles plus the loader latency.
- `frame_done` is high in the cycle after the final CLEAR, coincident with `go_ready` returning to 1.

## Structure
- Shared package `me_pkg`:
  - Constant `ME_CORE_CYCLES` = 4111.
  - State enum: IDLE, LOAD, RUN, PUSH, CLEAR.
  - Result struct: `mb_y`, `mb_x`, `motion_y`, `motion_x`, `best_dist`.
- One sub-module, `me_result_fifo`: parameterised synchronous FIFO with push/pop/full/empty outputs and an occupancy count.
- The FSM and the macroblock counters live in the top module.

## Test plan
- Single-macroblock frame (`MB_COLS`=`MB_ROWS`=1), core model returning dist 0x2A, mv (3,12); loader acks 5 cycles after `load_req`, `res_ready`=1 → one result 0x0_0_C_3_2A; `frame_done` once; `me_start` high for exactly 4111+1 cycles.
- 2×2 frame → four results with (`mb_y`,`mb_x`) in order 00, 01, 10, 11; `me_start` low for exactly one cycle between macroblocks; `go_valid` pulsed mid-frame is ignored.
- Backpressure: `res_ready`=0, `FIFO_DEPTH`=2, 2×2 frame → FSM stalls in PUSH on the 3rd macroblock with `me_start` held at 1 → raise `res_ready` → all 4 results delivered in order, none lost.
- Capture semantics: core model changes `me_best_dist` from 0x10 to 0x05 one cycle after `completed` → captured value is 0x10.
- Asynchronous reset asserted during RUN of macroblock 1 → in the same cycle `me_start`=0, `res_valid`=0, `busy`=0; a new go then restarts from (0,0).
- Simultaneous push and pop with occupancy 1 → occupancy stays 1, and the popped entry is the older one.
